uart_tx_cfg: RTL

Runtime-configurable UART transmitter with an internal transmit FIFO. It is the next-generation serial transmit path for the glitching controller's host link. Producers push bytes over a valid/ready handshake. Frame format (5–8 data bits, none/even/odd parity, 1 or 2 stop bits) and bit period are set per frame from configuration inputs. Queued bytes go out back-to-back with no idle gap between frames.

---
 rtl/uart_tx_cfg.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a small transmit FIFO and a per-frame latched format
// (5-8 data bits, none/even/odd parity, 1 or 2 stop bits, runtime bit period).
module uart_tx_cfg #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               s_valid,
    input  logic [7:0]                         s_data,
    output logic                               s_ready,
    input  logic [DIV_W-1:0]                   cfg_clks_per_bit,
    input  logic [1:0]                         cfg_data_bits,
    input  logic [1:0]                         cfg_parity,
    input  logic                               cfg_stop2,
    output logic                               tx,
    output logic                               tx_busy,
    output logic                               tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    // state  | meaning
    // IDLE   | line high, waiting for a queued byte
    // START  | start bit (low) for N clocks
    // DATA   | data bits LSB first, N clocks each
    // PARITY | optional parity bit, N clocks
    // STOP   | stop bit(s) high, N or 2N clocks
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    logic [2:0]       state;
    logic [DIV_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       fr_data;
    logic [DIV_W-1:0] fr_n;
    logic [2:0]       fr_last;
    logic [1:0]       fr_par;
    logic             fr_stop2;

    logic             bit_end;
    logic             stop_last;
    logic             par_en;
    logic             par_bit;
    logic             tx_next;
    logic             done_d;
    logic [7:0]       data_mask;

    assign s_ready   = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push      = s_valid && s_ready;
    assign bit_end   = (bit_cnt == fr_n - DIV_W'(1));
    assign stop_last = (state == STOP) && bit_end && (bit_idx == {2'b00, fr_stop2});
    assign pop       = (fifo_count != '0) && ((state == IDLE) || stop_last);
    assign par_en    = (fr_par == 2'd1) || (fr_par == 2'd2);
    // fr_data is masked at latch time, so the reduction covers only the sent bits
    assign par_bit   = (^fr_data) ^ (fr_par == 2'd2);
    assign data_mask = 8'hFF >> (2'd3 - cfg_data_bits);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            fr_data  <= '0;
            fr_n     <= DIV_W'(1);
            fr_last  <= 3'd7;
            fr_par   <= 2'd0;
            fr_stop2 <= 1'b0;
        end else if (pop) begin
            state    <= START;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            fr_data  <= mem[rd_ptr] & data_mask;
            fr_n     <= (cfg_clks_per_bit == '0) ? DIV_W'(1) : cfg_clks_per_bit;
            fr_last  <= {1'b0, cfg_data_bits} + 3'd4;
            fr_par   <= cfg_parity;
            fr_stop2 <= cfg_stop2;
        end else begin
            case (state)
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        bit_idx <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == fr_last) begin
                            bit_idx <= '0;
                            state   <= par_en ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + DIV_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state   <= STOP;
                        bit_cnt <= '0;
                        bit_idx <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (stop_last) begin
                            state   <= IDLE;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        tx_next = 1'b1;
        case (state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = fr_data[bit_idx];
            PARITY:  tx_next = par_bit;
            default: tx_next = 1'b1;
        endcase
    end

    // Line outputs are registered from the current state, so they trail the
    // internal state by one clock; tx_done is aligned to the same line timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            done_d  <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx      <= tx_next;
            tx_busy <= (state != IDLE);
            done_d  <= stop_last;
            tx_done <= done_d;
        end
    end

endmodule
